// File: rtl/fir_p2s_3.sv
// Parallel-to-serial converter: up to three lane samples per clock into a circular FIFO, one sample out per clock.
// Optional sticky overflow flag is enabled by defining P2S_OVF_FLAG_EN.
module fir_p2s_3 #(
    parameter int NB    = 14,
    parameter int DEPTH = 8
) (
    input  logic          Ck,
    input  logic          Rst,
    input  logic [NB-1:0] DIN_1,
    input  logic [NB-1:0] DIN_2,
    input  logic [NB-1:0] DIN_3,
    input  logic [2:0]    Vin,
    output logic          Ready,
    output logic [NB-1:0] Dout,
    output logic          Vout,
    input  logic          Rdy_in,
    output logic          Ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [NB-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic          w_rd;
    logic          w_wr;
    logic [1:0]    w_nlanes;
    logic [1:0]    w_nacc;
    logic [AW-1:0] w_a1;
    logic [AW-1:0] w_a2;
    logic [AW-1:0] w_a3;

    assign Vout     = (r_count != '0);
    assign Ready    = (r_count <= CW'(DEPTH - 3));
    assign Dout     = r_mem[r_rptr];
    assign w_rd     = Vout && Rdy_in;
    assign w_wr     = Ready && (Vin != 3'b000);
    assign w_nlanes = {1'b0, Vin[0]} + {1'b0, Vin[1]} + {1'b0, Vin[2]};
    assign w_nacc   = w_wr ? w_nlanes : 2'b00;

    // Compact the set lanes into consecutive slots, skipping unset ones.
    always_comb begin
        w_a1 = r_wptr;
        w_a2 = r_wptr + AW'(Vin[0]);
        w_a3 = r_wptr + AW'({1'b0, Vin[0]} + {1'b0, Vin[1]});
    end

    always_ff @(posedge Ck) begin
        if (w_wr) begin
            if (Vin[0]) r_mem[w_a1] <= DIN_1;
            if (Vin[1]) r_mem[w_a2] <= DIN_2;
            if (Vin[2]) r_mem[w_a3] <= DIN_3;
        end
    end

    always_ff @(posedge Ck or posedge Rst) begin
        if (Rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + AW'(w_nacc);
            r_rptr  <= r_rptr + AW'(w_rd);
            r_count <= r_count + CW'(w_nacc) - CW'(w_rd);
        end
    end

`ifdef P2S_OVF_FLAG_EN
    logic r_ovf;

    always_ff @(posedge Ck or posedge Rst) begin
        if (Rst) begin
            r_ovf <= 1'b0;
        end else if (!Ready && (Vin != 3'b000)) begin
            r_ovf <= 1'b1;
        end
    end

    assign Ovf = r_ovf;
`else
    assign Ovf = 1'b0;
`endif

endmodule

// File: tb/tb_fir_p2s_3.sv
// Self-checking bench for fir_p2s_3: queue-based reference model checked every cycle plus directed literal checks.
// Define P2S_OVF_FLAG_EN for both bench and RTL to exercise the sticky overflow flag.
module tb_fir_p2s_3;

    localparam int NB    = 14;
    localparam int DEPTH = 8;
`ifdef P2S_OVF_FLAG_EN
    localparam int OVF_EN = 1;
`else
    localparam int OVF_EN = 0;
`endif

    logic          Ck = 1'b0;
    logic          Rst;
    logic [NB-1:0] DIN_1, DIN_2, DIN_3;
    logic [2:0]    Vin;
    logic          Ready;
    logic [NB-1:0] Dout;
    logic          Vout;
    logic          Rdy_in;
    logic          Ovf;

    fir_p2s_3 #(.NB(NB), .DEPTH(DEPTH)) dut (
        .Ck(Ck), .Rst(Rst), .DIN_1(DIN_1), .DIN_2(DIN_2), .DIN_3(DIN_3),
        .Vin(Vin), .Ready(Ready), .Dout(Dout), .Vout(Vout),
        .Rdy_in(Rdy_in), .Ovf(Ovf)
    );

    initial forever #5 Ck = ~Ck;

    int n_vec = 0;
    int n_err = 0;
    int m_q[$];
    int m_ovf = 0;
    int outs[$];
    int sent[$];

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int out_at(input int i);
        if (i < outs.size()) return outs[i];
        return -1;
    endfunction

    // Reference model: a plain sample queue with a capacity rule.
    initial begin
        forever begin
            @(posedge Ck or posedge Rst);
            if (Rst) begin
                m_q.delete();
                m_ovf = 0;
            end else begin
                int  din[3];
                bit  can_take;
                din[0] = int'(DIN_1);
                din[1] = int'(DIN_2);
                din[2] = int'(DIN_3);
                can_take = (DEPTH - m_q.size()) >= 3;
                if (m_q.size() != 0 && Rdy_in) void'(m_q.pop_front());
                if (Vin != 3'b000) begin
                    if (can_take) begin
                        for (int l = 0; l < 3; l++)
                            if (Vin[l]) m_q.push_back(din[l]);
                    end else if (OVF_EN != 0) begin
                        m_ovf = 1;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge Ck);
            if (!Rst) begin
                check("vout", int'(Vout), int'(m_q.size() != 0));
                check("ready", int'(Ready), int'((DEPTH - m_q.size()) >= 3));
                check("ovf", int'(Ovf), m_ovf);
                if (m_q.size() != 0) check("dout", int'(Dout), m_q[0]);
                if (Vout && Rdy_in) outs.push_back(int'(Dout));
            end
        end
    end

    task automatic drive(input logic [2:0] v, input int a, input int b, input int c, input logic rdy);
        @(posedge Ck);
        #1;
        Vin    = v;
        DIN_1  = NB'(a);
        DIN_2  = NB'(b);
        DIN_3  = NB'(c);
        Rdy_in = rdy;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) drive(3'b000, 0, 0, 0, rdy);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        Rst = 1'b1; Vin = 3'b000; DIN_1 = '0; DIN_2 = '0; DIN_3 = '0; Rdy_in = 1'b1;
        #1;
        check("rst_vout", int'(Vout), 0);
        check("rst_ready", int'(Ready), 1);
        check("rst_ovf", int'(Ovf), 0);
        #22 Rst = 1'b0;

        // Single full triple drains in order with one-edge latency.
        outs.delete();
        drive(3'b111, 10, 20, 30, 1'b1);
        drive(3'b000, 0, 0, 0, 1'b1);
        @(negedge Ck);
        check("lat_vout", int'(Vout), 1);
        check("lat_dout", int'(Dout), 10);
        idle(5, 1'b1);
        check("t1_count", outs.size(), 3);
        check("t1_s0", out_at(0), 10);
        check("t1_s1", out_at(1), 20);
        check("t1_s2", out_at(2), 30);

        // Sparse lane masks compact without gaps.
        outs.delete();
        drive(3'b101, 5, 99, 7, 1'b1);
        drive(3'b110, 77, 11, 12, 1'b1);
        idle(6, 1'b1);
        check("t2_count", outs.size(), 4);
        check("t2_s0", out_at(0), 5);
        check("t2_s1", out_at(1), 7);
        check("t2_s2", out_at(2), 11);
        check("t2_s3", out_at(3), 12);

        // Backpressure: third triple is dropped once two are buffered.
        outs.delete();
        drive(3'b111, 1, 2, 3, 1'b0);
        drive(3'b111, 4, 5, 6, 1'b0);
        drive(3'b111, 7, 8, 9, 1'b0);
        drive(3'b000, 0, 0, 0, 1'b0);
        @(negedge Ck);
        check("full_ready", int'(Ready), 0);
        check("full_vout", int'(Vout), 1);
        check("full_ovf", int'(Ovf), OVF_EN);
        idle(9, 1'b1);
        check("t3_count", outs.size(), 6);
        for (int i = 0; i < 6; i++) check("t3_seq", out_at(i), i + 1);

        // Sustained full-rate input across several pointer wraps.
        outs.delete();
        sent.delete();
        for (int k = 0; k < 60; k++) begin
            @(posedge Ck);
            #1;
            Rdy_in = 1'b1;
            if (Ready) begin
                int v0, v1, v2;
                v0 = (k * 1571 + 9000) & 16383;
                v1 = (k * 1571 + 9333) & 16383;
                v2 = (k * 1571 + 9666) & 16383;
                Vin = 3'b111; DIN_1 = NB'(v0); DIN_2 = NB'(v1); DIN_3 = NB'(v2);
                sent.push_back(v0); sent.push_back(v1); sent.push_back(v2);
            end else begin
                Vin = 3'b000;
            end
        end
        idle(12, 1'b1);
        check("t4_count", outs.size(), sent.size());
        check("t4_wraps", int'(sent.size() >= 4 * DEPTH), 1);
        for (int i = 0; i < sent.size(); i++) check("t4_seq", out_at(i), sent[i]);

        // Asynchronous reset mid-drain with five samples buffered.
        drive(3'b111, 41, 42, 43, 1'b0);
        drive(3'b111, 44, 45, 46, 1'b0);
        drive(3'b000, 0, 0, 0, 1'b1);
        drive(3'b000, 0, 0, 0, 1'b0);
        check("pre_rst_vout", int'(Vout), 1);
        #3 Rst = 1'b1;
        #1;
        check("mid_rst_vout", int'(Vout), 0);
        check("mid_rst_ready", int'(Ready), 1);
        check("mid_rst_ovf", int'(Ovf), 0);
        #4 Rst = 1'b0;
        outs.delete();
        drive(3'b111, 1, 2, 3, 1'b1);
        idle(5, 1'b1);
        check("t5_count", outs.size(), 3);
        check("t5_s0", out_at(0), 1);
        check("t5_s1", out_at(1), 2);
        check("t5_s2", out_at(2), 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fir_p2s_3.md
# fir_p2s_3

Parallel-to-serial output converter for the 3-way unfolded FIR datapath. It accepts up to three filtered samples per clock (lanes 1..3, per-lane valid) from the unfolded filter's output port and re-serialises them, in sample order, onto a single-sample stream at most one sample per clock. Internal buffering is a small circular FIFO with downstream backpressure and upstream ready/overflow signalling. It sits between the unfolded filter outputs and the sample-serial back end (output writer or DAC interface).

## Interface
- NB, 14, sample width in bits (two's complement, passed through unchanged)
- DEPTH, 8, FIFO entries; power of two, >= 4

- Ck  in  1  system clock, all state updates on rising edge
- Rst  in  1  reset, asynchronous, active-high
- DIN_1  in  NB  lane-1 sample (oldest of the triple)
- DIN_2  in  NB  lane-2 sample
- DIN_3  in  NB  lane-3 sample (newest)
- Vin  in  3  per-lane valid; bit0=lane1, bit1=lane2, bit2=lane3
- Ready  out  1  high when >= 3 free entries; upstream may present Vin != 0
- Dout  out  NB  serial output sample (FIFO head)
- Vout  out  1  Dout valid (FIFO non-empty)
- Rdy_in  in  1  downstream accepts Dout this cycle
- Ovf  out  1  sticky overflow flag (see Configuration)

## Operation
- Storage: DEPTH x NB register array, write pointer, read pointer (log2 DEPTH bits, wrap modulo DEPTH), occupancy count (log2(DEPTH)+1 bits).
- Write: on an edge with Ready=1, each lane with Vin bit set is written in lane order 1,2,3 into consecutive slots from the write pointer; unset lanes are skipped (Vin=3'b101 writes DIN_1 then DIN_3 into adjacent slots). Write pointer advances by popcount(Vin).
- Read: a sample is consumed on an edge where Vout=1 and Rdy_in=1; read pointer advances by 1.
- Count update: count_next = count + popcount(Vin accepted) - read; simultaneous write and read in the same cycle are both honoured.
- Dout = mem[read pointer], Vout = (count != 0); when Vout=0, Dout is don't-care but must hold the last array value (no X).
- Ready = (DEPTH - count) >= 3, derived from registered count only (no combinational path from Rdy_in or Vin).
- Vin != 0 while Ready=0: entire triple discarded, no pointer/count change; Ovf set if enabled.
- Pointers wrap silently at DEPTH-1 -> 0; a triple may straddle the wrap.
- Reset: pointers 0, count 0, Ovf 0; array contents need not be cleared. Reset mid-stream discards all buffered samples immediately (asynchronous).

## Timing
- Reset values: Vout=0, Ready=1, Ovf=0, Dout=don't-care (no X after first write).
- Latency: sample written at edge N is visible on Dout/Vout after edge N when FIFO empty; a full triple at edge N drains at edges N+1, N+2, N+3 with Rdy_in=1.
- Throughput: 1 sample/clock out; sustained input Vin=3'b111 every cycle deasserts Ready within DEPTH/2 cycles.
- Rdy_in=0: Dout and Vout stable until accepted.
- Full: count=DEPTH -> Ready=0, Vout=1. Empty: count=0 -> Vout=0, Ready=1.

## Configuration
- P2S_OVF_FLAG_EN defined: Ovf is a sticky register, set on any cycle with Vin != 0 and Ready=0, cleared only by Rst.
- Not defined: Ovf tied to 0, no flag register synthesised; dropped triples remain silently discarded.

## Test plan
- Reset then Vin=3'b111 once with DIN=10,20,30, Rdy_in=1 -> Dout 10,20,30 on three consecutive cycles, Vout low on 4th; Ready stays 1.
- Vin=3'b101, DIN_1=5, DIN_3=7 -> Dout 5 then 7, no gap; lane 2 never appears.
- Rdy_in=0, Vin=3'b111 each cycle (DEPTH=8) -> Ready drops after 2 triples (count=6); third triple dropped, Ovf=1 with P2S_OVF_FLAG_EN, 0 without; release Rdy_in -> six samples out in order.
- Continuous Vin=3'b111 with Rdy_in=1 across >=4 pointer wraps -> output sequence equals input sequence, no loss while Ready honoured.
- Rst pulsed mid-drain with count=5 -> Vout=0, Ready=1, Ovf=0 asynchronously; next triple 1,2,3 emerges as 1,2,3.
